// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the fetch buffer: queue entry layout and reset PC.
// Entry layout: {fault, pc[31:2], 2'b00, inst}; the two zero bits keep the PC
// field byte-addressed so it can be unpacked as a full 32-bit PC.
package fetch_buffer_pkg;

    localparam int FB_ENTRY_W = 65;
    localparam logic [31:0] FB_RESET_PC = 32'h0000_0100;

    function automatic logic [FB_ENTRY_W-1:0] fb_pack(input logic fault,
                                                      input logic [29:0] pc_w,
                                                      input logic [31:0] inst);
        return {fault, pc_w, 2'b00, inst};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH x W storage with a registered head entry so the consumer
// sees flop outputs. Synchronous flush empties it in one cycle.
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = FB_ENTRY_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output logic [W-1:0]               head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, remain;
    logic [W-1:0]  head_q, head_d;
    logic          head_vld_q, head_vld_d;
    logic          pop_i, wr_en;

    // Next pointers/count and next head; a push into an otherwise-empty queue
    // bypasses storage straight into the head register.
    always_comb begin
        pop_i    = pop & (count_q != '0);
        wr_en    = push & ~flush;
        remain   = count_q - CW'(pop_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_i);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = remain + CW'(push);
        head_d   = '0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (count_d != '0) begin
            head_d = (remain == '0) ? wdata : mem_q[rd_ptr_d];
        end
        head_vld_d = (count_d != '0);
    end

    // Storage array, no reset needed: contents are qualified by count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    // Control and head registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    assign count      = count_q;
    assign head_valid = head_vld_q;
    assign head_data  = head_q;

    // The issue rule upstream must prevent pushes into a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && !pop_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: issues sequential word fetches, queues in-order responses with
// their PC, presents one instruction per cycle. Redirect flushes the queue and
// discards responses for requests already in flight.
// Optional: FETCH_BUF_FAULT_EN stores mem_fault per entry and halts fetch after
// a faulting response until the next redirect.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = FB_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    input  logic        mem_req_ready,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_fault,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    input  logic        out_stall
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUTST+1);

    logic [31:0]           fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [OW-1:0]         outst_q, outst_d, discard_q, discard_d;
    logic [CW-1:0]         fifo_count;
    logic [FB_ENTRY_W-1:0] head;
    logic                  head_vld, issue, keep, pop, fault_stop, push_fault;
    logic                  unused_bits;

    // Request gating: in-flight limit plus queue space reserved for every
    // outstanding response (stale ones included), so pushes never overflow.
    always_comb begin
        mem_req = ~reset & ~redirect & ~fault_stop
                & (outst_q < OW'(MAX_OUTST))
                & ((int'(fifo_count) + int'(outst_q)) < DEPTH);
        issue   = mem_req & mem_req_ready;
        keep    = mem_ack & ~redirect & (discard_q == '0) & ~fault_stop;
        pop     = head_vld & ~out_stall;
    end

    // Fetch/response PC, in-flight and discard counters; redirect overrides.
    always_comb begin
        fetch_pc_d = fetch_pc_q + (issue ? 32'd4 : 32'd0);
        resp_pc_d  = resp_pc_q + (keep ? 32'd4 : 32'd0);
        outst_d    = outst_q + OW'(issue) - OW'(mem_ack);
        discard_d  = discard_q;
        if (mem_ack && discard_q != '0) discard_d = discard_q - 1'b1;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            discard_d  = outst_q - OW'(mem_ack);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

`ifdef FETCH_BUF_FAULT_EN
    logic fault_stop_q, fault_stop_d;

    // Latch a kept faulting response; only a redirect restarts fetch.
    always_comb begin
        fault_stop_d = fault_stop_q;
        if (redirect)              fault_stop_d = 1'b0;
        else if (keep & mem_fault) fault_stop_d = 1'b1;
    end

    // Fault-stop register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fault_stop_q <= 1'b0;
        else       fault_stop_q <= fault_stop_d;
    end

    assign fault_stop = fault_stop_q;
    assign push_fault = mem_fault;
    assign out_fault  = head[FB_ENTRY_W-1];
`else
    assign fault_stop = 1'b0;
    assign push_fault = 1'b0;
    assign out_fault  = 1'b0;
`endif

    fetch_fifo #(.DEPTH(DEPTH), .W(FB_ENTRY_W)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (keep),
        .wdata      (fb_pack(push_fault, resp_pc_q[31:2], mem_rdata)),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (head_vld),
        .head_data  (head)
    );

    assign mem_addr  = fetch_pc_q[31:2];
    assign out_valid = head_vld;
    assign out_inst  = head[31:0];
    assign out_pc    = {head[63:34], 2'b00};

    assign unused_bits = ^{redirect_pc[1:0], fetch_pc_q[1:0], resp_pc_q[1:0],
                           head[33:32], head[64], mem_fault};

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: per-cycle vector table for streaming, plus
// hand sequences for stall/full, redirect, ready back-pressure and faults.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_req_ready, mem_ack, mem_fault;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect, out_valid, out_fault, out_stall;
    logic [31:0] redirect_pc, out_inst, out_pc;

    bit          ack_en;
    logic [29:0] fault_addr;
    int          nchk = 0, nerr = 0;

`ifdef FETCH_BUF_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    fetch_buffer dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_fault(mem_fault),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_fault(out_fault), .out_stall(out_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] idata(input logic [29:0] a);
        return 32'h5A00_0000 ^ {2'b00, a};
    endfunction

    // Memory model: in-order, acks each accepted request one cycle later.
    logic [29:0] pend[$];
    initial begin
        logic acc, ak, rs;
        logic [29:0] a;
        mem_ack = 1'b0; mem_rdata = '0; mem_fault = 1'b0;
        forever begin
            @(posedge clk);
            acc = mem_req & mem_req_ready; a = mem_addr; ak = mem_ack; rs = reset;
            #1;
            if (rs) begin
                pend.delete();
                mem_ack = 1'b0; mem_fault = 1'b0; mem_rdata = '0;
            end else begin
                if (ak) void'(pend.pop_front());
                if (acc) pend.push_back(a);
                if (ack_en && pend.size() > 0) begin
                    mem_ack = 1'b1; mem_rdata = idata(pend[0]);
                    mem_fault = (pend[0] == fault_addr);
                end else begin
                    mem_ack = 1'b0; mem_fault = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; sample/drive 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset(input bit ready, input bit stall);
        @(posedge clk); #2;
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_stall = stall;
        mem_req_ready = ready; ack_en = 1'b1; fault_addr = 30'h3FFF_FFFF;
        tick(); tick();
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        reset = 1'b0; #1;
    endtask

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [29:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t tv[6];

    initial begin
        int nv;
        bit seen104;
        tv[0] = '{1'b0, 1'b1, 30'h40, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tv[1] = '{1'b0, 1'b1, 30'h41, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tv[2] = '{1'b0, 1'b1, 30'h42, 1'b1, 32'h0000_0100, 32'h5A00_0040};
        tv[3] = '{1'b0, 1'b1, 30'h43, 1'b1, 32'h0000_0104, 32'h5A00_0041};
        tv[4] = '{1'b0, 1'b1, 30'h44, 1'b1, 32'h0000_0108, 32'h5A00_0042};
        tv[5] = '{1'b0, 1'b1, 30'h45, 1'b1, 32'h0000_010C, 32'h5A00_0043};

        redirect = 1'b0; redirect_pc = '0; out_stall = 1'b0; mem_req_ready = 1'b1;
        ack_en = 1'b1; fault_addr = 30'h3FFF_FFFF;
        tick(); tick();
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_fault", {31'd0, out_fault}, 0);

        // 1: streaming from reset, table driven.
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            out_stall = tv[i].stall; #1;
            chk($sformatf("t1_req[%0d]", i), {31'd0, mem_req}, {31'd0, tv[i].exp_req});
            chk($sformatf("t1_addr[%0d]", i), {2'b00, mem_addr}, {2'b00, tv[i].exp_addr});
            chk($sformatf("t1_valid[%0d]", i), {31'd0, out_valid}, {31'd0, tv[i].exp_valid});
            chk($sformatf("t1_pc[%0d]", i), out_pc, tv[i].exp_pc);
            chk($sformatf("t1_inst[%0d]", i), out_inst, tv[i].exp_inst);
            tick();
        end

        // 2: stalled consumer fills exactly DEPTH entries, then drains in order.
        do_reset(1'b1, 1'b1);
        tick(); tick(); tick();
        chk("t2_req_before_full", {31'd0, mem_req}, 1);
        chk("t2_addr_before_full", {2'b00, mem_addr}, 32'h43);
        tick();
        chk("t2_req_full", {31'd0, mem_req}, 0);
        tick(); tick(); tick();
        chk("t2_req_still_off", {31'd0, mem_req}, 0);
        chk("t2_head_pc", out_pc, 32'h100);
        out_stall = 1'b0;
        tick();
        chk("t2_pop1_pc", out_pc, 32'h104);
        chk("t2_resume_req", {31'd0, mem_req}, 1);
        chk("t2_resume_addr", {2'b00, mem_addr}, 32'h44);
        tick();
        chk("t2_pop2_pc", out_pc, 32'h108);
        tick();
        chk("t2_pop3_pc", out_pc, 32'h10C);
        tick();
        chk("t2_pop4_valid", {31'd0, out_valid}, 1);
        chk("t2_pop4_pc", out_pc, 32'h110);
        chk("t2_pop4_inst", out_inst, 32'h5A00_0044);

        // 3: two requests in flight, redirect drops both responses.
        do_reset(1'b1, 1'b0);
        ack_en = 1'b0;
        tick(); tick();
        chk("t3_outst_limit", {31'd0, mem_req}, 0);
        redirect = 1'b1; redirect_pc = 32'h2000;
        tick();
        redirect = 1'b0; ack_en = 1'b1; #1;
        for (int k = 0; k < 20 && !mem_req; k++) tick();
        chk("t3_req_timeout", {31'd0, mem_req}, 1);
        chk("t3_new_addr", {2'b00, mem_addr}, 32'h800);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("t3_valid_timeout", {31'd0, out_valid}, 1);
        chk("t3_first_pc", out_pc, 32'h2000);
        chk("t3_first_inst", out_inst, 32'h5A00_0800);

        // 4: redirect coinciding with an ack and a pop.
        do_reset(1'b1, 1'b0);
        repeat (5) tick();
        chk("t4_pre_pc", out_pc, 32'h10C);
        redirect = 1'b1; redirect_pc = 32'h3003; #1;
        chk("t4_req_forced_off", {31'd0, mem_req}, 0);
        tick();
        redirect = 1'b0; #1;
        chk("t4_flushed", {31'd0, out_valid}, 0);
        for (int k = 0; k < 20 && !mem_req; k++) tick();
        chk("t4_req_timeout", {31'd0, mem_req}, 1);
        chk("t4_new_addr", {2'b00, mem_addr}, 32'hC00);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("t4_valid_timeout", {31'd0, out_valid}, 1);
        chk("t4_first_pc", out_pc, 32'h3000);
        chk("t4_first_inst", out_inst, 32'h5A00_0C00);

        // 5: memory not ready for 3 cycles.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5_req[%0d]", i), {31'd0, mem_req}, 1);
            chk($sformatf("t5_addr[%0d]", i), {2'b00, mem_addr}, 32'h40);
            chk($sformatf("t5_novalid[%0d]", i), {31'd0, out_valid}, 0);
            tick();
        end
        mem_req_ready = 1'b1; #1;
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("t5_valid_timeout", {31'd0, out_valid}, 1);
        chk("t5_first_pc", out_pc, 32'h100);
        chk("t5_first_inst", out_inst, 32'h5A00_0040);
        tick();
        chk("t5_second_pc", out_pc, 32'h104);
        chk("t5_second_inst", out_inst, 32'h5A00_0041);

        // 6: fault on the second response.
        do_reset(1'b1, 1'b0);
        fault_addr = 30'h41;
        nv = 0; seen104 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                nv++;
                if (out_pc == 32'h104) seen104 = 1'b1;
                chk($sformatf("t6_fault[%0h]", out_pc), {31'd0, out_fault},
                    {31'd0, FE && out_pc == 32'h104});
            end
            tick();
        end
        chk("t6_seen104", {31'd0, seen104}, 1);
        chk("t6_req_after_fault", {31'd0, mem_req}, {31'd0, !FE});
        chk("t6_nvalid", nv, FE ? 2 : 8);
        fault_addr = 30'h3FFF_FFFF;
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0; #1;
        for (int k = 0; k < 20 && !mem_req; k++) tick();
        chk("t6_req_resume", {31'd0, mem_req}, 1);
        chk("t6_resume_addr", {2'b00, mem_addr}, 32'h80);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("t6_resume_pc", out_pc, 32'h200);
        chk("t6_resume_fault", {31'd0, out_fault}, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
